// File: rtl/niosii_system_sysid_checker.sv
// Boot-time Avalon-MM master: reads sysid word 0 (ID) then word 1 (timestamp),
// compares both against build constants and publishes registered pass/fail flags.
module niosii_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h58A2_1A99,
  parameter int unsigned CHECK_TS       = 1,
  parameter int unsigned AUTO_START     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned   CW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT_CYCLES);
  localparam logic [2:0]    RETRY_LIM = 3'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    retry_q, retry_d;
  logic          avm_read_q, avm_read_d;
  logic          avm_address_q, avm_address_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   id_q, id_d;
  logic [31:0]   ts_q, ts_d;

  logic in_req, in_wait, ts_word, accept, data_in, expire, check_ok;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    retry_d       = retry_q;
    avm_read_d    = avm_read_q;
    avm_address_d = avm_address_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    timeout_d     = timeout_q;
    id_d          = id_q;
    ts_d          = ts_q;

    in_req   = (state_q == S_ID_REQ) || (state_q == S_TS_REQ);
    in_wait  = (state_q == S_ID_WAIT) || (state_q == S_TS_WAIT);
    ts_word  = (state_q == S_TS_REQ) || (state_q == S_TS_WAIT);
    accept   = in_req && !avm_waitrequest;
    // Data in the acceptance cycle (zero-latency slave) counts, and beats expiry.
    data_in  = avm_readdatavalid && (in_wait || accept);
    expire   = (in_req || in_wait) && !data_in && (cnt_q >= CNT_LAST);
    check_ok = (id_q == EXPECTED_ID) && ((CHECK_TS == 0) || (avm_readdata == EXPECTED_TS));

    if (in_req || in_wait) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (((state_q == S_IDLE) && (AUTO_START != 0)) || start) begin
          state_d       = S_ID_REQ;
          avm_read_d    = 1'b1;
          avm_address_d = 1'b0;
          cnt_d         = '0;
          retry_d       = '0;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          fail_d        = 1'b0;
          timeout_d     = 1'b0;
        end
      end
      S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT: begin
        if (data_in) begin
          if (ts_word) begin
            ts_d       = avm_readdata;
            state_d    = S_DONE;
            avm_read_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            pass_d     = check_ok;
            fail_d     = !check_ok;
            timeout_d  = 1'b0;
          end else begin
            id_d          = avm_readdata;
            state_d       = S_TS_REQ;
            avm_read_d    = 1'b1;
            avm_address_d = 1'b1;
            cnt_d         = '0;
            retry_d       = '0;
          end
        end else if (expire) begin
          if (retry_q < RETRY_LIM) begin
            retry_d    = retry_q + 1'b1;
            state_d    = ts_word ? S_TS_REQ : S_ID_REQ;
            avm_read_d = 1'b1;
            cnt_d      = '0;
          end else begin
            state_d    = S_DONE;
            avm_read_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            pass_d     = 1'b0;
            fail_d     = 1'b1;
            timeout_d  = 1'b1;
          end
        end else if (accept) begin
          state_d    = ts_word ? S_TS_WAIT : S_ID_WAIT;
          avm_read_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      retry_q       <= '0;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_q     <= 1'b0;
      id_q          <= '0;
      ts_q          <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      timeout_q     <= timeout_d;
      id_q          <= id_d;
      ts_q          <= ts_d;
    end
  end

  assign avm_address = avm_address_q;
  assign avm_read    = avm_read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = timeout_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Bench for the sysid checker: behavioural sysid slave, directed runs, and a
// scoreboard that checks each completed sequence when done rises.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] TS_OK  = 32'h58A2_1A99;
  localparam logic [31:0] TS_BAD = 32'h58A2_1A98;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, start, waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        avm_address, avm_read, busy, done, pass, fail, timeout;
  logic [31:0] id_value, ts_value;
  logic        n_address, n_read, n_busy, n_done, n_pass, n_fail, n_timeout;
  logic [31:0] n_id_value, n_ts_value;

  niosii_system_sysid_checker #(
    .CHECK_TS(1), .AUTO_START(1), .TIMEOUT_CYCLES(8), .MAX_RETRIES(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(waitrequest),
    .avm_readdata(readdata), .avm_readdatavalid(readdatavalid),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );

  // Same inputs, timestamp compare disabled: follows the same trajectory.
  niosii_system_sysid_checker #(
    .CHECK_TS(0), .AUTO_START(1), .TIMEOUT_CYCLES(8), .MAX_RETRIES(2)
  ) dut_nots (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(n_address), .avm_read(n_read), .avm_waitrequest(waitrequest),
    .avm_readdata(readdata), .avm_readdatavalid(readdatavalid),
    .busy(n_busy), .done(n_done), .pass(n_pass), .fail(n_fail), .timeout(n_timeout),
    .id_value(n_id_value), .ts_value(n_ts_value)
  );

  // Slave model configuration, driven by the stimulus process.
  logic [31:0] id_data, ts_data;
  int unsigned dly;
  bit          zl, no_rdv, no_rdv_ts, stray;

  logic        rdv_q = 1'b0;
  logic [31:0] rd_q  = '0;
  int unsigned pend  = 0;
  int unsigned acc0  = 0;
  int unsigned acc1  = 0;
  int unsigned cyc   = 0;

  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rdv_q <= 1'b0;
    if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) rdv_q <= 1'b1;
    end
    if (avm_read && !waitrequest) begin
      if (avm_address) acc1 <= acc1 + 1;
      else             acc0 <= acc0 + 1;
      if (!zl) begin
        rd_q <= avm_address ? ts_data : id_data;
        if (!(no_rdv || (no_rdv_ts && avm_address))) begin
          if (dly <= 1) rdv_q <= 1'b1;
          else          pend  <= dly - 1;
        end
      end
    end
  end

  assign readdatavalid = stray | (zl ? (avm_read & ~waitrequest) : rdv_q);
  assign readdata      = stray ? 32'hDEAD_BEEF :
                         zl    ? (avm_address ? ts_data : id_data) : rd_q;

  typedef struct {
    int unsigned cyc;
    logic        pass, fail, to, npass;
    logic [31:0] id, ts;
    int unsigned a0, a1;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic        done_d = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // lat: cycles from now until done is seen (0 = don't check timing).
  task automatic expect_run(input int unsigned lat, input logic ep, input logic ef,
                            input logic et, input logic enp, input logic [31:0] eid,
                            input logic [31:0] ets, input int unsigned d0, input int unsigned d1);
    exp_t e;
    e.cyc = (lat == 0) ? 0 : cyc + lat;
    e.pass = ep; e.fail = ef; e.to = et; e.npass = enp;
    e.id = eid; e.ts = ets;
    e.a0 = acc0 + d0; e.a1 = acc1 + d1;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    if (done && !done_d) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != 0) chk("done_cycle", cyc, mon_e.cyc);
        chk("pass", 32'(pass), 32'(mon_e.pass));
        chk("fail", 32'(fail), 32'(mon_e.fail));
        chk("timeout", 32'(timeout), 32'(mon_e.to));
        chk("id_value", id_value, mon_e.id);
        chk("ts_value", ts_value, mon_e.ts);
        chk("reads_word0", acc0, mon_e.a0);
        chk("reads_word1", acc1, mon_e.a1);
        chk("nots_done", 32'(n_done), 32'd1);
        chk("nots_pass", 32'(n_pass), 32'(mon_e.npass));
        chk("nots_fail", 32'(n_fail), 32'(!mon_e.npass));
        chk("nots_timeout", 32'(n_timeout), 32'(mon_e.to));
        chk("nots_id", n_id_value, mon_e.id);
        chk("nots_ts", n_ts_value, mon_e.ts);
      end
    end
    done_d <= done;
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_read"}, 32'(avm_read), 32'd0);
    chk({tag, "_addr"}, 32'(avm_address), 32'd0);
    chk({tag, "_id"}, id_value, 32'd0);
    chk({tag, "_ts"}, ts_value, 32'd0);
    chk({tag, "_nots_busy"}, 32'(n_busy), 32'd0);
    chk({tag, "_nots_read"}, 32'(n_read), 32'd0);
    chk({tag, "_nots_addr"}, 32'(n_address), 32'd0);
  endtask

  // Pulse start from DONE; flags must already be cleared one edge later.
  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk({tag, "_clr_done"}, 32'(done), 32'd0);
    chk({tag, "_clr_pass"}, 32'(pass), 32'd0);
    chk({tag, "_clr_fail"}, 32'(fail), 32'd0);
    chk({tag, "_clr_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int unsigned budget);
    for (int unsigned i = 0; i < budget && !done; i++) @(negedge clock);
    if (!done) chk({tag, "_done_wait"}, 32'(done), 32'd1);
    @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; waitrequest = 1'b0;
    id_data = 32'h0; ts_data = TS_OK; dly = 1;
    zl = 1'b0; no_rdv = 1'b0; no_rdv_ts = 1'b0; stray = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset("rst");

    // Auto-start after reset; a start pulse while busy must change nothing.
    expect_run(5, 1, 0, 0, 1, 32'h0, TS_OK, 1, 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("r1_busy_mid", 32'(busy), 32'd1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done("r1", 40);

    // Wrong timestamp: fails with compare enabled, passes with it disabled.
    ts_data = TS_BAD;
    expect_run(5, 0, 1, 0, 1, 32'h0, TS_BAD, 1, 1);
    pulse_start("r2");
    wait_done("r2", 40);

    // Ten stall cycles on word 0 (one internal retry): request held stable.
    ts_data = TS_OK;
    waitrequest = 1'b1;
    expect_run(15, 1, 0, 0, 1, 32'h0, TS_OK, 1, 1);
    pulse_start("r3");
    repeat (10) begin
      chk("r3_read_held", 32'(avm_read), 32'd1);
      chk("r3_addr_held", 32'(avm_address), 32'd0);
      @(negedge clock);
    end
    chk("r3_read_held", 32'(avm_read), 32'd1);
    waitrequest = 1'b0;
    wait_done("r3", 40);

    // No readdatavalid ever: 3 attempts on word 0, then timeout; old values kept.
    no_rdv = 1'b1;
    expect_run(25, 0, 1, 1, 0, 32'h0, TS_OK, 3, 0);
    pulse_start("r4");
    wait_done("r4", 80);
    no_rdv = 1'b0;

    // Data arriving exactly on the expiry cycle is captured, no timeout.
    dly = 7;
    expect_run(17, 1, 0, 0, 1, 32'h0, TS_OK, 1, 1);
    pulse_start("r5");
    wait_done("r5", 60);
    dly = 1;

    // Zero-latency slave: data in the acceptance cycle, wait states skipped.
    zl = 1'b1;
    ts_data = TS_BAD;
    expect_run(3, 0, 1, 0, 1, 32'h0, TS_BAD, 1, 1);
    pulse_start("r6");
    wait_done("r6", 40);
    zl = 1'b0;
    ts_data = TS_OK;

    // Reset while waiting on the timestamp, then a stray readdatavalid on release.
    no_rdv_ts = 1'b1;
    pulse_start("r7");
    for (int unsigned i = 0; i < 20 && !(avm_address && !avm_read && busy); i++)
      @(negedge clock);
    chk("r7_in_ts_wait", 32'(avm_address && !avm_read && busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    chk_reset("r7_rst");
    no_rdv_ts = 1'b0;
    stray = 1'b1;
    expect_run(5, 1, 0, 0, 1, 32'h0, TS_OK, 1, 1);
    reset_n = 1'b1;
    @(negedge clock);
    stray = 1'b0;
    chk("r7_stray_ignored", id_value, 32'h0);
    chk("r7_rerun_busy", 32'(busy), 32'd1);
    wait_done("r7", 40);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
